// File: rtl/mat_stream_loader.sv
// mat_stream_loader: stores up to four row-major matrices and streams paired
// A/B elements with their dimensions into the matrix-operation engine.
module mat_stream_loader #(
    parameter int SLOTS   = 4,
    parameter int MAX_DIM = 5,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    input  logic [1:0]    cfg_slot,
    input  logic [2:0]    cfg_m,
    input  logic [2:0]    cfg_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          store_done,
    input  logic          rd_start,
    input  logic [1:0]    rd_slot_a,
    input  logic [1:0]    rd_slot_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic          out_last,
    output logic [2:0]    dim_a_m,
    output logic [2:0]    dim_a_n,
    output logic [2:0]    dim_b_m,
    output logic [2:0]    dim_b_n,
    output logic          busy,
    output logic          cfg_error,
    output logic          rd_error
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t          state_q, state_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [2:0]      sm_q [SLOTS];
    logic [2:0]      sm_d [SLOTS];
    logic [2:0]      sn_q [SLOTS];
    logic [2:0]      sn_d [SLOTS];
    logic [1:0]      wslot_q, wslot_d;
    logic [4:0]      wlen_q, wlen_d;
    logic [4:0]      idx_q, idx_d;
    logic [4:0]      len_q, len_d;
    logic [4:0]      la_q, la_d;
    logic [4:0]      lb_q, lb_d;
    logic [1:0]      ra_q, ra_d;
    logic [1:0]      rb_q, rb_d;
    logic [2:0]      dam_q, dam_d, dan_q, dan_d, dbm_q, dbm_d, dbn_q, dbn_d;
    logic [DW-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic            store_done_q, store_done_d;
    logic            cfg_error_q, cfg_error_d;
    logic            rd_error_q, rd_error_d;
    logic            cfg_legal, rd_go;
    logic [4:0]      len_a_req, len_b_req;
    logic [DW-1:0]   mem [SLOTS*MAX_DIM*MAX_DIM];

    function automatic logic [6:0] base(input logic [1:0] s);
        return 7'(s) * 7'd25;
    endfunction

    assign cfg_legal = cfg_m != 3'd0 && 32'(cfg_m) <= MAX_DIM && cfg_n != 3'd0 && 32'(cfg_n) <= MAX_DIM;
    assign len_a_req = 5'(sm_q[rd_slot_a]) * 5'(sn_q[rd_slot_a]);
    assign len_b_req = 5'(sm_q[rd_slot_b]) * 5'(sn_q[rd_slot_b]);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        sm_d         = sm_q;
        sn_d         = sn_q;
        wslot_d      = wslot_q;
        wlen_d       = wlen_q;
        idx_d        = idx_q;
        len_d        = len_q;
        la_d         = la_q;
        lb_d         = lb_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        dam_d        = dam_q;
        dan_d        = dan_q;
        dbm_d        = dbm_q;
        dbn_d        = dbn_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        store_done_d = 1'b0;
        cfg_error_d  = 1'b0;
        rd_error_d   = 1'b0;
        rd_go        = 1'b0;
        case (state_q)
            IDLE: begin
                // cfg wins over a same-cycle rd_start, even when the cfg is rejected
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        state_d           = WRITE;
                        wslot_d           = cfg_slot;
                        valid_d[cfg_slot] = 1'b0;
                        sm_d[cfg_slot]    = cfg_m;
                        sn_d[cfg_slot]    = cfg_n;
                        wlen_d            = 5'(cfg_m) * 5'(cfg_n);
                        idx_d             = 5'd0;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end else if (rd_start) begin
                    if (valid_q[rd_slot_a] && valid_q[rd_slot_b]) begin
                        state_d = READ;
                        ra_d    = rd_slot_a;
                        rb_d    = rd_slot_b;
                        dam_d   = sm_q[rd_slot_a];
                        dan_d   = sn_q[rd_slot_a];
                        dbm_d   = sm_q[rd_slot_b];
                        dbn_d   = sn_q[rd_slot_b];
                        la_d    = len_a_req;
                        lb_d    = len_b_req;
                        len_d   = len_a_req > len_b_req ? len_a_req : len_b_req;
                        idx_d   = 5'd0;
                        rd_go   = 1'b1;
                    end else begin
                        rd_error_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == wlen_q - 5'd1) begin
                        valid_d[wslot_q] = 1'b1;
                        store_done_d     = 1'b1;
                        state_d          = IDLE;
                    end
                end
            end
            READ: begin
                if (out_ready) begin
                    idx_d = idx_q + 5'd1;
                    rd_go = 1'b1;
                    if (idx_q == len_q - 5'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // registered array read: fetch the pair that will be presented next
        if (rd_go) begin
            out_a_d = idx_d < la_d ? mem[base(ra_d) + 7'(idx_d)] : '0;
            out_b_d = idx_d < lb_d ? mem[base(rb_d) + 7'(idx_d)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WRITE && wr_valid) mem[base(wslot_q) + 7'(idx_q)] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            sm_q         <= '{default: '0};
            sn_q         <= '{default: '0};
            wslot_q      <= '0;
            wlen_q       <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            la_q         <= '0;
            lb_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            dam_q        <= '0;
            dan_q        <= '0;
            dbm_q        <= '0;
            dbn_q        <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            store_done_q <= 1'b0;
            cfg_error_q  <= 1'b0;
            rd_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            sm_q         <= sm_d;
            sn_q         <= sn_d;
            wslot_q      <= wslot_d;
            wlen_q       <= wlen_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            la_q         <= la_d;
            lb_q         <= lb_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            dam_q        <= dam_d;
            dan_q        <= dan_d;
            dbm_q        <= dbm_d;
            dbn_q        <= dbn_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            store_done_q <= store_done_d;
            cfg_error_q  <= cfg_error_d;
            rd_error_q   <= rd_error_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign wr_ready   = state_q == WRITE;
    assign out_valid  = state_q == READ;
    assign out_last   = out_valid && idx_q == len_q - 5'd1;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign dim_a_m    = dam_q;
    assign dim_a_n    = dan_q;
    assign dim_b_m    = dbm_q;
    assign dim_b_n    = dbn_q;
    assign store_done = store_done_q;
    assign cfg_error  = cfg_error_q;
    assign rd_error   = rd_error_q;
endmodule

// File: tb/tb_mat_stream_loader.sv
// tb_mat_stream_loader: directed checks of storage, streaming, padding,
// backpressure, error pulses and reset behaviour of mat_stream_loader.
module tb_mat_stream_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_slot = '0;
    logic [2:0] cfg_m = '0, cfg_n = '0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, store_done;
    logic       rd_start = 1'b0;
    logic [1:0] rd_slot_a = '0, rd_slot_b = '0;
    logic       out_valid, out_ready = 1'b0;
    logic [7:0] out_a, out_b;
    logic       out_last;
    logic [2:0] dim_a_m, dim_a_n, dim_b_m, dim_b_n;
    logic       busy, cfg_error, rd_error;
    int         errors = 0;
    int         checks = 0;

    mat_stream_loader dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_slot(cfg_slot),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .store_done(store_done), .rd_start(rd_start),
        .rd_slot_a(rd_slot_a), .rd_slot_b(rd_slot_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_last(out_last),
        .dim_a_m(dim_a_m), .dim_a_n(dim_a_n), .dim_b_m(dim_b_m), .dim_b_n(dim_b_n),
        .busy(busy), .cfg_error(cfg_error), .rd_error(rd_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] s, input logic [2:0] m, input logic [2:0] n);
        cfg_valid = 1'b1; cfg_slot = s; cfg_m = m; cfg_n = n;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] v);
        chk("wr_ready", wr_ready, 1);
        wr_valid = 1'b1; wr_data = v;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [1:0] b);
        rd_start = 1'b1; rd_slot_a = a; rd_slot_b = b;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        chk("pair_valid", out_valid, 1);
        chk("pair_a", out_a, a);
        chk("pair_b", out_b, b);
        chk("pair_last", out_last, last);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int k, acc;
        logic [15:0] pat;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_store_done", store_done, 0);
        chk("rst_cfg_error", cfg_error, 0);
        chk("rst_rd_error", rd_error, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_dims", {dim_a_m, dim_a_n, dim_b_m, dim_b_n}, 0);

        // read of an empty slot after reset
        rd(2'd3, 2'd3);
        chk("empty_rd_error", rd_error, 1);
        chk("empty_busy", busy, 0);
        chk("empty_out_valid", out_valid, 0);
        tick();
        chk("empty_rd_error_end", rd_error, 0);
        chk("empty_out_valid2", out_valid, 0);

        // 2x3 into slot 0, then read-after-write the cycle after store_done
        cfg(2'd0, 3'd2, 3'd3);
        chk("cfg_busy", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            chk("pre_store_done", store_done, 0);
            wr(8'(i));
        end
        chk("store_done", store_done, 1);
        chk("store_busy", busy, 0);
        rd(2'd0, 2'd0);
        chk("store_done_end", store_done, 0);
        chk("dims_s0", {dim_a_m, dim_a_n, dim_b_m, dim_b_n}, {3'd2, 3'd3, 3'd2, 3'd3});
        for (int i = 1; i <= 6; i++) pair(8'(i), 8'(i), i == 6);
        chk("s0_end_valid", out_valid, 0);
        chk("s0_end_busy", busy, 0);

        // mismatched lengths with write gaps
        cfg(2'd1, 3'd3, 3'd2);
        for (int i = 10; i <= 15; i++) begin
            wr(8'(i));
            if (i == 12) begin
                tick();
                tick();
                chk("gap_wr_ready", wr_ready, 1);
            end
        end
        chk("s1_store_done", store_done, 1);
        cfg(2'd2, 3'd1, 3'd1);
        wr(8'd7);
        rd(2'd1, 2'd2);
        chk("dims_12", {dim_a_m, dim_a_n, dim_b_m, dim_b_n}, {3'd3, 3'd2, 3'd1, 3'd1});
        pair(8'd10, 8'd7, 0);
        for (int i = 11; i <= 15; i++) pair(8'(i), 8'd0, i == 15);
        chk("s12_end_valid", out_valid, 0);

        // illegal configurations
        cfg(2'd0, 3'd0, 3'd3);
        chk("m0_cfg_error", cfg_error, 1);
        chk("m0_busy", busy, 0);
        tick();
        chk("m0_cfg_error_end", cfg_error, 0);
        cfg(2'd3, 3'd6, 3'd2);
        chk("m6_cfg_error", cfg_error, 1);
        chk("m6_wr_ready", wr_ready, 0);
        tick();
        chk("m6_cfg_error_end", cfg_error, 0);
        rd(2'd3, 2'd0);
        chk("m6_slot_still_empty", rd_error, 1);
        rd(2'd0, 2'd0);
        chk("m0_slot_kept_dims", {dim_a_m, dim_a_n}, {3'd2, 3'd3});
        for (int i = 1; i <= 6; i++) pair(8'(i), 8'(i), i == 6);

        // backpressure on a 2x2
        cfg(2'd3, 3'd2, 3'd2);
        for (int i = 21; i <= 24; i++) wr(8'(i));
        rd(2'd3, 2'd3);
        pat = 16'b1111_1111_0010_1001;
        k = 0;
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            if (!out_valid) break;
            chk("bp_a", out_a, 21 + k);
            chk("bp_b", out_b, 21 + k);
            chk("bp_last", out_last, k == 3);
            out_ready = pat[c];
            tick();
            if (pat[c]) begin
                k++;
                acc++;
            end
        end
        out_ready = 1'b0;
        chk("bp_accepts", acc, 4);
        chk("bp_end_valid", out_valid, 0);

        // simultaneous cfg+rd, rd during WRITE, write gap
        cfg_valid = 1'b1; cfg_slot = 2'd2; cfg_m = 3'd1; cfg_n = 3'd2;
        rd_start = 1'b1; rd_slot_a = 2'd0; rd_slot_b = 2'd0;
        tick();
        cfg_valid = 1'b0;
        chk("sim_wr_ready", wr_ready, 1);
        chk("sim_out_valid", out_valid, 0);
        chk("sim_rd_error", rd_error, 0);
        tick();
        rd_start = 1'b0;
        chk("rd_in_write_ready", wr_ready, 1);
        chk("rd_in_write_valid", out_valid, 0);
        wr(8'd40);
        tick();
        wr(8'd41);
        chk("s2_store_done", store_done, 1);
        rd(2'd2, 2'd1);
        chk("dims_21", {dim_a_m, dim_a_n, dim_b_m, dim_b_n}, {3'd1, 3'd2, 3'd3, 3'd2});
        pair(8'd40, 8'd10, 0);
        pair(8'd41, 8'd11, 0);
        for (int i = 12; i <= 15; i++) pair(8'd0, 8'(i), i == 15);

        // reset mid-write
        cfg(2'd0, 3'd2, 3'd3);
        wr(8'd50);
        wr(8'd51);
        wr(8'd52);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy", busy, 0);
        chk("rstw_wr_ready", wr_ready, 0);
        rd(2'd0, 2'd0);
        chk("rstw_rd_error", rd_error, 1);
        chk("rstw_out_valid", out_valid, 0);

        // reset mid-stream
        cfg(2'd1, 3'd1, 3'd3);
        wr(8'd60);
        wr(8'd61);
        wr(8'd62);
        rd(2'd1, 2'd1);
        pair(8'd60, 8'd60, 0);
        chk("rsts_pair1", out_a, 61);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsts_out_valid", out_valid, 0);
        chk("rsts_busy", busy, 0);
        chk("rsts_out_last", out_last, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mat_stream_loader.md
# mat_stream_loader

Matrix storage and streaming stage placed directly upstream of the matrix-operation engine. Holds up to four row-major matrices with their dimensions, as written from the input/UART parser. On request it streams a paired A/B element sequence plus dimensions into the operation engine, one element pair per accepted beat. It also flags malformed dimensions and reads of empty slots.

## Interface
- SLOTS, 4: number of matrix slots; slot index width is 2.
- MAX_DIM, 5: maximum rows or columns per matrix.
- DW, 8: element width.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  begin storing a matrix; sampled only in IDLE
- cfg_slot  in  2  target slot
- cfg_m  in  3  rows, legal 1..MAX_DIM
- cfg_n  in  3  columns, legal 1..MAX_DIM
- wr_valid  in  1  element beat valid
- wr_data  in  DW  element, row-major order
- wr_ready  out  1  high throughout WRITE
- store_done  out  1  one-cycle pulse when the last element is stored
- rd_start  in  1  begin streaming; sampled only in IDLE
- rd_slot_a  in  2  slot streamed on out_a
- rd_slot_b  in  2  slot streamed on out_b
- out_valid  out  1  output pair valid
- out_ready  in  1  consumer accepts the pair
- out_a  out  DW  element of A, or 0 past A's length
- out_b  out  DW  element of B, or 0 past B's length
- out_last  out  1  qualifies the final pair
- dim_a_m, dim_a_n, dim_b_m, dim_b_n  out  3 each  dimensions latched at rd_start
- busy  out  1  state is not IDLE
- cfg_error  out  1  one-cycle pulse on an illegal cfg
- rd_error  out  1  one-cycle pulse on a read of an empty slot

## Operation
- **Storage:** SLOTS×MAX_DIM² byte array; address = slot·25 + idx. There is a per-slot valid bit and m/n registers.
- **States:** IDLE, WRITE, READ.
- **IDLE → WRITE** on cfg_valid with legal dims:
  - Latch slot, m and n.
  - Clear the slot's valid bit in that cycle.
  - Set idx = 0.
- **Illegal cfg** (m or n is 0 or greater than 5): pulse cfg_error, stay in IDLE, leave the slot untouched.
- **WRITE:**
  - Each cycle with wr_valid=1 writes wr_data at idx, then idx++.
  - On the beat where idx = m·n−1: set the valid bit, pulse store_done in the next cycle, return to IDLE.
  - wr_valid=0 stalls indefinitely.
- **IDLE → READ** on rd_start when both slots are valid:
  - Latch the dims onto the dim_* outputs.
  - Set len = max(mA·nA, mB·nB) and idx = 0.
- **Empty slot on rd_start** (either slot invalid): pulse rd_error, stay in IDLE, leave dim_* unchanged.
- **READ:**
  - The pair at idx is presented with out_valid=1.
  - out_a = A[idx] if idx < mA·nA, else 0. out_b follows the same rule for B.
  - The pair advances only on out_valid & out_ready.
  - out_last=1 when idx = len−1. Acceptance of the last pair returns to IDLE, with out_valid=0 in the next cycle.
- **Same slot for A and B:** allowed; both outputs carry identical data.
- **Simultaneous cfg_valid and rd_start in IDLE:** cfg takes priority and rd_start is dropped, with no error.
- **cfg_valid or rd_start while busy:** ignored.
- **Reset:**
  - Clears all valid bits, state, counters and outputs.
  - Array contents are not cleared; they are unreachable until rewritten.
  - Reset mid-WRITE leaves that slot invalid.
  - Reset mid-READ aborts the stream; out_valid is 0 in the cycle after rst.

## Timing
- Reset values: wr_ready, store_done, out_valid, out_last, busy, cfg_error and rd_error are 0. out_a, out_b and all dim_* are 0.
- cfg_valid at edge t: busy=1 and wr_ready=1 from t+1. The first element is accepted at t+1 at the earliest.
- Last write beat at edge t: store_done=1 and busy=0 during t+1 only. A new cfg or rd is accepted at t+1.
- rd_start at edge t: out_valid=1 with pair 0 from t+1, because the array read is registered.
- Pair k accepted at edge t: pair k+1 is valid from t+1. Full throughput is one pair per cycle when out_ready is held high.
- out_ready=0: out_a, out_b, out_last and idx hold stable.
- Read-after-write is legal the cycle after store_done and returns the new data.
- cfg_error and rd_error assert in the cycle after the offending request and last exactly one cycle.

## Test plan
- **Store 2×3 in slot 0:** cfg(0,2,3), then wr 1..6 → wr_ready high for ≥6 cycles and store_done pulses once. Then rd_start(a=0,b=0) → pairs (1,1)…(6,6), out_last on the 6th, dim_a=2×3.
- **Mismatched lengths:** slot1 = 3×2 holding 10..15, slot2 = 1×1 holding 7. rd(a=1,b=2) → 6 pairs: (10,7), (11,0)…(15,0), with dims 3×2 and 1×1.
- **Errors:**
  - cfg m=0 → cfg_error pulse and slot state unchanged.
  - cfg m=6 → cfg_error pulse.
  - rd of empty slot 3 after reset → rd_error pulse, busy stays 0, out_valid stays 0.
- **Backpressure:** stream a 2×2; toggle out_ready 1,0,0,1,… → each pair is held while ready=0, with no skipped or duplicated elements. Exactly 4 acceptances occur.
- **Simultaneous and ignored requests:**
  - cfg_valid with rd_start in the same IDLE cycle → enters WRITE and no stream appears.
  - rd_start during WRITE → ignored.
  - wr_valid gaps in WRITE → stall with the correct data stored.
- **Reset mid-operation:**
  - Assert rst after 3 of 6 writes → that slot reads as rd_error afterward.
  - Assert rst mid-stream → out_valid=0 the next cycle and busy=0.
